color_key_filter: RTL and testbench

//  Pipelined, parametrised colour-dominance key for the VGA pixel stream. Selected channel (R/G/B) must exceed

---
 rtl/color_key_filter_if.sv | 55 +++++
 rtl/color_key_filter.sv | 247 ++++++++++++++++++++++++
 tb/tb_color_key_filter.sv | 206 ++++++++++++++++++++
 3 files changed

// File: rtl/color_key_filter_if.sv
// Pixel stream bundle for color_key_filter: keyed input pixels, filtered output pixels and frame stats.
// Bounding-box ports exist only when COLOR_KEY_BBOX_EN is defined.
interface color_key_filter_if #(
  parameter int unsigned DW = 10,
  parameter int unsigned CW = 20
`ifdef COLOR_KEY_BBOX_EN
  ,
  parameter int unsigned XW = 11,
  parameter int unsigned YW = 10
`endif
);
  logic          iDVAL;
  logic          iSOF;
  logic [DW-1:0] iR;
  logic [DW-1:0] iG;
  logic [DW-1:0] iB;
  logic [1:0]    iKEY_SEL;
  logic [7:0]    iTHRESH;

  logic          oDVAL;
  logic [DW-1:0] oR;
  logic [DW-1:0] oG;
  logic [DW-1:0] oB;
  logic [DW-1:0] oBIN;
  logic          oMASK;
  logic [CW-1:0] oPASS_CNT;
  logic          oSTAT_VALID;

`ifdef COLOR_KEY_BBOX_EN
  logic [XW-1:0] oX_MIN;
  logic [XW-1:0] oX_MAX;
  logic [YW-1:0] oY_MIN;
  logic [YW-1:0] oY_MAX;

  modport master (
    output iDVAL, iSOF, iR, iG, iB, iKEY_SEL, iTHRESH,
    input  oDVAL, oR, oG, oB, oBIN, oMASK, oPASS_CNT, oSTAT_VALID,
    input  oX_MIN, oX_MAX, oY_MIN, oY_MAX
  );
  modport slave (
    input  iDVAL, iSOF, iR, iG, iB, iKEY_SEL, iTHRESH,
    output oDVAL, oR, oG, oB, oBIN, oMASK, oPASS_CNT, oSTAT_VALID,
    output oX_MIN, oX_MAX, oY_MIN, oY_MAX
  );
`else
  modport master (
    output iDVAL, iSOF, iR, iG, iB, iKEY_SEL, iTHRESH,
    input  oDVAL, oR, oG, oB, oBIN, oMASK, oPASS_CNT, oSTAT_VALID
  );
  modport slave (
    input  iDVAL, iSOF, iR, iG, iB, iKEY_SEL, iTHRESH,
    output oDVAL, oR, oG, oB, oBIN, oMASK, oPASS_CNT, oSTAT_VALID
  );
`endif
endinterface

// File: rtl/color_key_filter.sv
// color_key_filter: 3-stage colour-dominance key with per-frame pass statistics.
// Optional bounding-box statistics are enabled by defining COLOR_KEY_BBOX_EN.
module color_key_filter #(
  parameter int unsigned DW       = 10,
  parameter int unsigned H_ACTIVE = 640,
  parameter int unsigned CW       = 20,
  parameter int unsigned XW       = 11,
  parameter int unsigned YW       = 10
) (
  input logic               iCLK,
  input logic               iRST_N,
  color_key_filter_if.slave pix
);
  localparam int unsigned   KW         = 8;
  localparam logic [1:0]    KEY_G      = 2'd1;
  localparam logic [1:0]    KEY_B      = 2'd2;
  localparam logic [1:0]    KEY_BYPASS = 2'd3;
  localparam logic [XW-1:0] X_LAST     = XW'(H_ACTIVE - 1);

  typedef enum logic {IDLE, RUN} statsStateT;

  logic                 startPix;
  logic [1:0]           modeLat, modeEff;
  logic [KW-1:0]        thrLat, thrEff, keyCh, oth1, oth2;
  logic signed [KW:0]   diff1, diff2;

  logic                 s1Valid, s1Sof, s1Bypass;
  logic [DW-1:0]        s1R, s1G, s1B;
  logic signed [KW:0]   s1Diff1, s1Diff2;
  logic [KW-1:0]        s1Thr;

  logic                 s2Valid, s2Sof, s2Pass, keep;
  logic [DW-1:0]        s2R, s2G, s2B;
  logic                 s3Sof;

  statsStateT           state, stateNext;
  logic [CW-1:0]        cnt, cntNext, passCntNext;
  logic                 statValidNext;
  logic [XW-1:0]        xPos, xPosNext, coordX;
  logic [YW-1:0]        yPos, yPosNext, coordY;

  // A SOF pixel already uses the mode/threshold it carries.
  assign startPix = pix.iDVAL && pix.iSOF;
  assign modeEff  = startPix ? pix.iKEY_SEL : modeLat;
  assign thrEff   = startPix ? pix.iTHRESH  : thrLat;

  always_comb begin
    keyCh = pix.iR[DW-1 -: KW];
    oth1  = pix.iG[DW-1 -: KW];
    oth2  = pix.iB[DW-1 -: KW];
    case (modeEff)
      KEY_G: begin
        keyCh = pix.iG[DW-1 -: KW];
        oth1  = pix.iR[DW-1 -: KW];
      end
      KEY_B: begin
        keyCh = pix.iB[DW-1 -: KW];
        oth1  = pix.iR[DW-1 -: KW];
        oth2  = pix.iG[DW-1 -: KW];
      end
      default: ;
    endcase
    diff1 = $signed({1'b0, keyCh}) - $signed({1'b0, oth1});
    diff2 = $signed({1'b0, keyCh}) - $signed({1'b0, oth2});
  end

  always_ff @(posedge iCLK or negedge iRST_N) begin : stage1
    if (!iRST_N) begin
      modeLat  <= 2'd0;
      thrLat   <= 8'h20;
      s1Valid  <= 1'b0;
      s1Sof    <= 1'b0;
      s1Bypass <= 1'b0;
      s1R      <= '0;
      s1G      <= '0;
      s1B      <= '0;
      s1Diff1  <= '0;
      s1Diff2  <= '0;
      s1Thr    <= '0;
    end else begin
      s1Valid <= pix.iDVAL;
      s1Sof   <= startPix;
      if (startPix) begin
        modeLat <= pix.iKEY_SEL;
        thrLat  <= pix.iTHRESH;
      end
      if (pix.iDVAL) begin
        s1R      <= pix.iR;
        s1G      <= pix.iG;
        s1B      <= pix.iB;
        s1Diff1  <= diff1;
        s1Diff2  <= diff2;
        s1Thr    <= thrEff;
        s1Bypass <= (modeEff == KEY_BYPASS);
      end
    end
  end

  always_ff @(posedge iCLK or negedge iRST_N) begin : stage2
    if (!iRST_N) begin
      s2Valid <= 1'b0;
      s2Sof   <= 1'b0;
      s2Pass  <= 1'b0;
      s2R     <= '0;
      s2G     <= '0;
      s2B     <= '0;
    end else begin
      s2Valid <= s1Valid;
      s2Sof   <= s1Sof;
      if (s1Valid) begin
        s2Pass <= s1Bypass || ((s1Diff1 >= $signed({1'b0, s1Thr})) &&
                               (s1Diff2 >= $signed({1'b0, s1Thr})));
        s2R    <= s1R;
        s2G    <= s1G;
        s2B    <= s1B;
      end
    end
  end

  assign keep = s2Valid && s2Pass;

  always_ff @(posedge iCLK or negedge iRST_N) begin : stage3
    if (!iRST_N) begin
      pix.oDVAL <= 1'b0;
      pix.oMASK <= 1'b0;
      pix.oR    <= '0;
      pix.oG    <= '0;
      pix.oB    <= '0;
      pix.oBIN  <= '0;
      s3Sof     <= 1'b0;
    end else begin
      pix.oDVAL <= s2Valid;
      pix.oMASK <= keep;
      pix.oR    <= keep ? s2R : '0;
      pix.oG    <= keep ? s2G : '0;
      pix.oB    <= keep ? s2B : '0;
      pix.oBIN  <= {DW{keep}};
      s3Sof     <= s2Valid && s2Sof;
    end
  end

`ifdef COLOR_KEY_BBOX_EN
  logic [XW-1:0] xMinRun, xMaxRun, xMinNext, xMaxNext, xMinOutNext, xMaxOutNext;
  logic [YW-1:0] yMinRun, yMaxRun, yMinNext, yMaxNext, yMinOutNext, yMaxOutNext;
`endif

  // Stats FSM works on the S3 pixel; frame N is reported at the SOF of frame N+1.
  always_comb begin
    stateNext     = state;
    cntNext       = cnt;
    passCntNext   = pix.oPASS_CNT;
    statValidNext = 1'b0;
    xPosNext      = xPos;
    yPosNext      = yPos;
    coordX        = s3Sof ? '0 : xPos;
    coordY        = s3Sof ? '0 : yPos;
`ifdef COLOR_KEY_BBOX_EN
    xMinNext    = xMinRun;
    xMaxNext    = xMaxRun;
    yMinNext    = yMinRun;
    yMaxNext    = yMaxRun;
    xMinOutNext = pix.oX_MIN;
    xMaxOutNext = pix.oX_MAX;
    yMinOutNext = pix.oY_MIN;
    yMaxOutNext = pix.oY_MAX;
`endif
    if (pix.oDVAL) begin
      if (coordX == X_LAST) begin
        xPosNext = '0;
        yPosNext = (coordY == '1) ? coordY : coordY + 1'b1;
      end else begin
        xPosNext = coordX + 1'b1;
        yPosNext = coordY;
      end

      if (s3Sof) begin
        if (state == RUN) begin
          passCntNext   = cnt;
          statValidNext = 1'b1;
`ifdef COLOR_KEY_BBOX_EN
          xMinOutNext = xMinRun;
          xMaxOutNext = xMaxRun;
          yMinOutNext = yMinRun;
          yMaxOutNext = yMaxRun;
`endif
        end
        stateNext = RUN;
        cntNext   = CW'(pix.oMASK);
`ifdef COLOR_KEY_BBOX_EN
        xMinNext = '1;
        xMaxNext = '0;
        yMinNext = '1;
        yMaxNext = '0;
`endif
      end else if (state == RUN && pix.oMASK && cnt != '1) begin
        cntNext = cnt + 1'b1;
      end

`ifdef COLOR_KEY_BBOX_EN
      if (pix.oMASK && (s3Sof || state == RUN)) begin
        if (coordX < xMinNext) xMinNext = coordX;
        if (coordX > xMaxNext) xMaxNext = coordX;
        if (coordY < yMinNext) yMinNext = coordY;
        if (coordY > yMaxNext) yMaxNext = coordY;
      end
`endif
    end
  end

  always_ff @(posedge iCLK or negedge iRST_N) begin : statsReg
    if (!iRST_N) begin
      state           <= IDLE;
      cnt             <= '0;
      xPos            <= '0;
      yPos            <= '0;
      pix.oPASS_CNT   <= '0;
      pix.oSTAT_VALID <= 1'b0;
`ifdef COLOR_KEY_BBOX_EN
      xMinRun    <= '1;
      xMaxRun    <= '0;
      yMinRun    <= '1;
      yMaxRun    <= '0;
      pix.oX_MIN <= '0;
      pix.oX_MAX <= '0;
      pix.oY_MIN <= '0;
      pix.oY_MAX <= '0;
`endif
    end else begin
      state           <= stateNext;
      cnt             <= cntNext;
      xPos            <= xPosNext;
      yPos            <= yPosNext;
      pix.oPASS_CNT   <= passCntNext;
      pix.oSTAT_VALID <= statValidNext;
`ifdef COLOR_KEY_BBOX_EN
      xMinRun    <= xMinNext;
      xMaxRun    <= xMaxNext;
      yMinRun    <= yMinNext;
      yMaxRun    <= yMaxNext;
      pix.oX_MIN <= xMinOutNext;
      pix.oX_MAX <= xMaxOutNext;
      pix.oY_MIN <= yMinOutNext;
      pix.oY_MAX <= yMaxOutNext;
`endif
    end
  end
endmodule

// File: tb/tb_color_key_filter.sv
// Directed bench for color_key_filter: a 20-bit-count DUT and a 4-bit-count DUT share one stimulus.
// Bounding-box checks are compiled in when COLOR_KEY_BBOX_EN is defined.
module tb_color_key_filter;
  logic clk = 1'b0;
  logic rstN;
  int   vectors     = 0;
  int   miscompares = 0;
  int   statPulses  = 0;

  always #5 clk = ~clk;

`ifdef COLOR_KEY_BBOX_EN
  color_key_filter_if #(.DW(10), .CW(20), .XW(11), .YW(10)) busA ();
  color_key_filter_if #(.DW(10), .CW(4),  .XW(11), .YW(10)) busB ();
`else
  color_key_filter_if #(.DW(10), .CW(20)) busA ();
  color_key_filter_if #(.DW(10), .CW(4))  busB ();
`endif

  color_key_filter #(.DW(10), .H_ACTIVE(640), .CW(20), .XW(11), .YW(10)) dutA (
    .iCLK(clk), .iRST_N(rstN), .pix(busA.slave));
  color_key_filter #(.DW(10), .H_ACTIVE(640), .CW(4), .XW(11), .YW(10)) dutB (
    .iCLK(clk), .iRST_N(rstN), .pix(busB.slave));

  always @(negedge clk) if (busA.oSTAT_VALID) statPulses++;

  task automatic checkVal(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic pix(input logic dv, input logic sof, input logic [9:0] r, input logic [9:0] g,
                     input logic [9:0] b, input logic [1:0] key, input logic [7:0] thr);
    busA.iDVAL = dv;  busA.iSOF = sof; busA.iR = r; busA.iG = g; busA.iB = b;
    busA.iKEY_SEL = key; busA.iTHRESH = thr;
    busB.iDVAL = dv;  busB.iSOF = sof; busB.iR = r; busB.iG = g; busB.iB = b;
    busB.iKEY_SEL = key; busB.iTHRESH = thr;
    @(posedge clk); #1;
  endtask

  task automatic idle();
    busA.iDVAL = 1'b0; busA.iSOF = 1'b0;
    busB.iDVAL = 1'b0; busB.iSOF = 1'b0;
    @(posedge clk); #1;
  endtask

  // Pixel just driven reaches the outputs after two more edges.
  task automatic checkPix(input string tag, input logic mask, input logic [9:0] r,
                          input logic [9:0] g, input logic [9:0] b);
    idle();
    idle();
    checkVal({tag, "_dval"}, 32'(busA.oDVAL), 32'd1);
    checkVal({tag, "_mask"}, 32'(busA.oMASK), 32'(mask));
    checkVal({tag, "_bin"},  32'(busA.oBIN), mask ? 32'h3FF : 32'h0);
    checkVal({tag, "_r"},    32'(busA.oR), 32'(r));
    checkVal({tag, "_g"},    32'(busA.oG), 32'(g));
    checkVal({tag, "_b"},    32'(busA.oB), 32'(b));
  endtask

  task automatic checkIdleOut(input string tag);
    checkVal({tag, "_dval"},  32'(busA.oDVAL), 32'd0);
    checkVal({tag, "_mask"},  32'(busA.oMASK), 32'd0);
    checkVal({tag, "_rgb"},   32'(busA.oR | busA.oG | busA.oB | busA.oBIN), 32'd0);
    checkVal({tag, "_cntA"},  32'(busA.oPASS_CNT), 32'd0);
    checkVal({tag, "_cntB"},  32'(busB.oPASS_CNT), 32'd0);
    checkVal({tag, "_stat"},  32'(busA.oSTAT_VALID | busB.oSTAT_VALID), 32'd0);
  endtask

  task automatic waitStat(input string tag, input logic [31:0] expA, input logic [31:0] expB);
    int n = 0;
    while (!busA.oSTAT_VALID && n < 10) begin
      idle();
      n++;
    end
    checkVal({tag, "_seen"},   32'(busA.oSTAT_VALID), 32'd1);
    checkVal({tag, "_seenB"},  32'(busB.oSTAT_VALID), 32'd1);
    checkVal({tag, "_cntA"},   32'(busA.oPASS_CNT), expA);
    checkVal({tag, "_cntB"},   32'(busB.oPASS_CNT), expB);
  endtask

  task automatic endStat(input string tag);
    idle();
    checkVal({tag, "_pulse1"}, 32'(busA.oSTAT_VALID), 32'd0);
  endtask

`ifdef COLOR_KEY_BBOX_EN
  task automatic checkBbox(input string tag, input logic [10:0] xMin, input logic [10:0] xMax,
                           input logic [9:0] yMin, input logic [9:0] yMax);
    checkVal({tag, "_xmin"}, 32'(busA.oX_MIN), 32'(xMin));
    checkVal({tag, "_xmax"}, 32'(busA.oX_MAX), 32'(xMax));
    checkVal({tag, "_ymin"}, 32'(busA.oY_MIN), 32'(yMin));
    checkVal({tag, "_ymax"}, 32'(busA.oY_MAX), 32'(yMax));
  endtask
`endif

  initial begin
    int base;
    logic [9:0] r, g;
    logic [1:0] key;
    rstN = 1'b0;
    busA.iDVAL = 1'b0; busA.iSOF = 1'b0; busA.iR = '0; busA.iG = '0; busA.iB = '0;
    busA.iKEY_SEL = 2'd0; busA.iTHRESH = 8'h20;
    busB.iDVAL = 1'b0; busB.iSOF = 1'b0; busB.iR = '0; busB.iG = '0; busB.iB = '0;
    busB.iKEY_SEL = 2'd0; busB.iTHRESH = 8'h20;

    // Reset held while pixels stream in.
    for (int i = 0; i < 5; i++) pix(1'b1, 1'b1, 10'h3FC, 10'h000, 10'h000, 2'd0, 8'h20);
    checkIdleOut("rst");
    rstN = 1'b1;
    idle();
    idle();
    checkIdleOut("post_rst");

    // Red key, latency and basic pass/fail.
    pix(1'b1, 1'b1, 10'h3FC, 10'h100, 10'h080, 2'd0, 8'h20);
    idle();
    checkVal("lat2_dval", 32'(busA.oDVAL), 32'd0);
    idle();
    checkVal("lat3_dval", 32'(busA.oDVAL), 32'd1);
    checkVal("red_mask",  32'(busA.oMASK), 32'd1);
    checkVal("red_bin",   32'(busA.oBIN), 32'h3FF);
    checkVal("red_r",     32'(busA.oR), 32'h3FC);
    pix(1'b1, 1'b0, 10'h100, 10'h3FC, 10'h000, 2'd0, 8'h20);
    checkPix("neg_diff", 1'b0, 10'h0, 10'h0, 10'h0);

    // Threshold boundary on the top 8 bits.
    pix(1'b1, 1'b0, 10'h180, 10'h100, 10'h000, 2'd0, 8'h20);
    checkPix("thr_eq", 1'b1, 10'h180, 10'h100, 10'h000);
    pix(1'b1, 1'b0, 10'h180, 10'h104, 10'h000, 2'd0, 8'h20);
    checkPix("thr_m1", 1'b0, 10'h0, 10'h0, 10'h0);
    pix(1'b1, 1'b0, 10'h180, 10'h103, 10'h000, 2'd0, 8'h20);
    checkPix("thr_lsb", 1'b1, 10'h180, 10'h103, 10'h000);
    pix(1'b1, 1'b1, 10'h200, 10'h200, 10'h200, 2'd0, 8'h00);
    checkPix("thr0_eq", 1'b1, 10'h200, 10'h200, 10'h200);
    pix(1'b1, 1'b1, 10'h000, 10'h3FF, 10'h3FF, 2'd3, 8'h20);
    checkPix("bypass", 1'b1, 10'h000, 10'h3FF, 10'h3FF);
    pix(1'b1, 1'b1, 10'h000, 10'h3FC, 10'h000, 2'd1, 8'h20);
    checkPix("key_g", 1'b1, 10'h000, 10'h3FC, 10'h000);
    pix(1'b1, 1'b0, 10'h3FC, 10'h000, 10'h000, 2'd0, 8'h20);
    checkPix("key_hold", 1'b0, 10'h0, 10'h0, 10'h0);
    pix(1'b1, 1'b1, 10'h000, 10'h000, 10'h3FC, 2'd2, 8'h20);
    checkPix("key_b", 1'b1, 10'h000, 10'h000, 10'h3FC);

    // Mid-frame reset; the next SOF must start from IDLE without a stats pulse.
    rstN = 1'b0;
    idle();
    checkIdleOut("mid_rst");
    rstN = 1'b1;
    idle();
    base = statPulses;

    // Frame 1: 640x4, 37 red pixels, key changed mid-frame, with iDVAL gaps.
    for (int i = 0; i < 2560; i++) begin
      r   = ((i % 64) == 0 && i < 2368) ? 10'h3FC : 10'h000;
      key = (i >= 1000) ? 2'd1 : 2'd0;
      pix(1'b1, i == 0, r, 10'h000, 10'h000, key, 8'h20);
      if ((i % 100) == 50) idle();
    end

    // Frame 2: green key now active from its SOF; passes at (5,1) and (600,3).
    for (int i = 0; i < 2540; i++) begin
      r = (i == 0) ? 10'h3FC : 10'h000;
      g = (i == 645 || i == 2520) ? 10'h3FC : 10'h000;
      pix(1'b1, i == 0, r, g, 10'h000, 2'd1, 8'h20);
      if (i == 0) begin
        idle();
        idle();
        checkVal("key_next_sof", 32'(busA.oMASK), 32'd0);
        waitStat("f1", 32'd37, 32'd15);
`ifdef COLOR_KEY_BBOX_EN
        checkBbox("f1", 11'd0, 11'd576, 10'd0, 10'd3);
`endif
        endStat("f1");
      end
    end

    // Frame 3: empty.
    for (int i = 0; i < 50; i++) begin
      pix(1'b1, i == 0, 10'h000, 10'h000, 10'h000, 2'd1, 8'h20);
      if (i == 0) begin
        waitStat("f2", 32'd2, 32'd2);
`ifdef COLOR_KEY_BBOX_EN
        checkBbox("f2", 11'd5, 11'd600, 10'd1, 10'd3);
`endif
        endStat("f2");
      end
    end

    // Frame 4 SOF closes the empty frame.
    pix(1'b1, 1'b1, 10'h000, 10'h000, 10'h000, 2'd1, 8'h20);
    waitStat("f3", 32'd0, 32'd0);
`ifdef COLOR_KEY_BBOX_EN
    checkBbox("f3", 11'h7FF, 11'h000, 10'h3FF, 10'h000);
`endif
    endStat("f3");

    for (int i = 0; i < 5; i++) idle();
    checkVal("stat_pulses", 32'(statPulses - base), 32'd3);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
